// File: rtl/sobel_output_stage.sv
// Output stage for the Sobel magnitude stream: per-frame threshold, raster SOF/EOL tagging,
// and a first-word-fall-through FIFO toward a ready/valid sink. Overflow drops beats and is sticky.
module sobel_output_stage #(
    parameter int unsigned WIDTH_P  = 640,
    parameter int unsigned HEIGHT_P = 480,
    parameter int unsigned DEPTH_P  = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         valid_i,
    input  logic [7:0]                   pixel_i,
    input  logic [7:0]                   threshold_i,
    input  logic                         binarize_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [7:0]                   pixel_o,
    output logic                         sof_o,
    output logic                         eol_o,
    output logic [$clog2(DEPTH_P+1)-1:0] fill_o,
    output logic                         overflow_o
);

    localparam int unsigned COL_W   = (WIDTH_P  > 1) ? $clog2(WIDTH_P)  : 1;
    localparam int unsigned ROW_W   = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;
    localparam int unsigned PTR_W   = $clog2(DEPTH_P);
    localparam int unsigned FILL_W  = $clog2(DEPTH_P + 1);
    localparam int unsigned ENTRY_W = 10;

    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic [7:0]         r_thr;
    logic               r_bin;
    logic [ENTRY_W-1:0] r_mem [DEPTH_P];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [FILL_W-1:0]  r_fill;
    logic               r_valid;
    logic               r_overflow;

    logic               w_sof;
    logic               w_eol;
    logic               w_last_col;
    logic               w_last_row;
    logic [7:0]         w_thr;
    logic               w_bin;
    logic [7:0]         w_pix;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [FILL_W-1:0]  w_fill_next;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_head;

    // Beat classification and threshold; the SOF beat uses the live settings it latches.
    always_comb begin
        w_last_col = (r_col == COL_W'(WIDTH_P - 1));
        w_last_row = (r_row == ROW_W'(HEIGHT_P - 1));
        w_sof      = (r_col == '0) && (r_row == '0);
        w_eol      = w_last_col;
        w_thr      = w_sof ? threshold_i : r_thr;
        w_bin      = w_sof ? binarize_i  : r_bin;
        w_pix      = 8'h00;
        if (pixel_i >= w_thr) begin
            w_pix = w_bin ? 8'hFF : pixel_i;
        end
        w_entry    = {w_pix, w_sof, w_eol};
    end

    // FIFO control: a full FIFO refuses the push even when the head pops this cycle.
    always_comb begin
        w_full      = (r_fill == FILL_W'(DEPTH_P));
        w_push      = valid_i && !w_full;
        w_pop       = r_valid && ready_i;
        w_fill_next = r_fill;
        case ({w_push, w_pop})
            2'b10:   w_fill_next = r_fill + FILL_W'(1);
            2'b01:   w_fill_next = r_fill - FILL_W'(1);
            default: w_fill_next = r_fill;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_col <= '0;
            r_row <= '0;
            r_thr <= '0;
            r_bin <= 1'b0;
        end else if (valid_i) begin
            if (w_sof) begin
                r_thr <= threshold_i;
                r_bin <= binarize_i;
            end
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (valid_i && w_full) begin
                r_overflow <= 1'b1;
            end
            r_fill  <= w_fill_next;
            r_valid <= (w_fill_next != '0);
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_comb begin
        w_head     = r_mem[r_rd_ptr];
        valid_o    = r_valid;
        pixel_o    = r_valid ? w_head[9:2] : 8'h00;
        sof_o      = r_valid && w_head[1];
        eol_o      = r_valid && w_head[0];
        fill_o     = r_fill;
        overflow_o = r_overflow;
    end

endmodule

// File: tb/tb_sobel_output_stage.sv
// Directed bench for sobel_output_stage on a 4x2 frame with a 16-deep FIFO, checked every cycle
// against a queue-based model plus literal expectations on the accepted output stream.
module tb_sobel_output_stage;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int DEPTH = 16;
    localparam int FRAME = W * H;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       valid_i = 1'b0;
    logic [7:0] pixel_i = 8'h00;
    logic [7:0] threshold_i = 8'h00;
    logic       binarize_i = 1'b0;
    logic       ready_i = 1'b0;
    logic       valid_o;
    logic [7:0] pixel_o;
    logic       sof_o;
    logic       eol_o;
    logic [4:0] fill_o;
    logic       overflow_o;

    sobel_output_stage #(.WIDTH_P(W), .HEIGHT_P(H), .DEPTH_P(DEPTH)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .pixel_i(pixel_i),
        .threshold_i(threshold_i), .binarize_i(binarize_i), .valid_o(valid_o),
        .ready_i(ready_i), .pixel_o(pixel_o), .sof_o(sof_o), .eol_o(eol_o),
        .fill_o(fill_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;
    int tb_idx = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: stream of beats in raster order, FIFO as a queue.
    typedef struct packed { logic [7:0] pix; logic sof; logic eol; } beat_t;
    beat_t      mq[$];
    int         m_idx = 0;
    logic [7:0] m_thr = 8'h00;
    logic       m_bin = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_pop;
    logic       m_full;
    beat_t      m_b;
    logic [7:0] m_t;
    logic       m_bn;

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mq.delete();
            m_idx = 0; m_thr = 8'h00; m_bin = 1'b0; m_ovf = 1'b0;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_pop  = (mq.size() > 0) && ready_i;
            if (valid_i) begin
                m_b.sof = (m_idx == 0);
                m_b.eol = ((m_idx % W) == W - 1);
                if (m_b.sof) begin m_thr = threshold_i; m_bin = binarize_i; end
                m_t  = m_thr;
                m_bn = m_bin;
                if (pixel_i < m_t)  m_b.pix = 8'h00;
                else if (m_bn)      m_b.pix = 8'hFF;
                else                m_b.pix = pixel_i;
                if (m_full) m_ovf = 1'b1;
                else        mq.push_back(m_b);
                m_idx = (m_idx + 1) % FRAME;
            end
            if (m_pop) void'(mq.pop_front());
        end
    end

    logic [9:0] log_q[$];

    // Per-cycle compare against the model; also records every beat the sink accepts.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            chk("cyc_valid", int'(valid_o), int'(mq.size() > 0));
            chk("cyc_fill", int'(fill_o), mq.size());
            chk("cyc_overflow", int'(overflow_o), int'(m_ovf));
            if (mq.size() > 0) begin
                chk("cyc_pixel", int'(pixel_o), int'(mq[0].pix));
                chk("cyc_sof", int'(sof_o), int'(mq[0].sof));
                chk("cyc_eol", int'(eol_o), int'(mq[0].eol));
            end else begin
                chk("cyc_idle_out", int'({pixel_o, sof_o, eol_o}), 0);
            end
            if (valid_o && ready_i) log_q.push_back({pixel_o, sof_o, eol_o});
        end
    end

    task automatic beat(input logic [7:0] p);
        valid_i = 1'b1;
        pixel_i = p;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        tb_idx = (tb_idx + 1) % FRAME;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic finish_frame();
        while (tb_idx != 0) beat(8'h11);
    endtask

    task automatic chk_log(input string nm, input int idx, input int pix, input int sof, input int eol);
        if (idx >= log_q.size()) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: only %0d beats received, need index %0d", nm, log_q.size(), idx);
        end else begin
            chk({nm, "_pix"}, int'(log_q[idx][9:2]), pix);
            chk({nm, "_sof"}, int'(log_q[idx][1]), sof);
            chk({nm, "_eol"}, int'(log_q[idx][0]), eol);
        end
    endtask

    initial begin
        #3;
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_fill", int'(fill_o), 0);
        chk("rst_overflow", int'(overflow_o), 0);
        chk("rst_out", int'({pixel_o, sof_o, eol_o}), 0);
        @(posedge clk_i); #2;
        reset_i = 1'b0;
        @(posedge clk_i); #1;

        // Passthrough: frame of 0..7, then the next frame's first beat
        ready_i = 1'b1; threshold_i = 8'h00; binarize_i = 1'b0;
        log_q.delete();
        for (int i = 0; i < FRAME; i++) beat(8'(i));
        beat(8'h55);
        idle(3);
        chk("pass_count", log_q.size(), 9);
        for (int i = 0; i < FRAME; i++)
            chk_log($sformatf("pass%0d", i), i, i, int'(i == 0), int'(i == 3 || i == 7));
        chk_log("pass_f2", 8, 8'h55, 1, 0);
        finish_frame();
        idle(2);

        // Binarize at 0x80, mid-frame change to 0x10 takes effect next frame
        log_q.delete();
        threshold_i = 8'h80; binarize_i = 1'b1;
        beat(8'h7F); beat(8'h80); beat(8'h20);
        threshold_i = 8'h10;
        beat(8'h0F); beat(8'h10); beat(8'hFF);
        finish_frame();
        beat(8'h0F); beat(8'h10);
        idle(3);
        chk_log("bin0", 0, 8'h00, 1, 0);
        chk_log("bin1", 1, 8'hFF, 0, 0);
        chk_log("bin2", 2, 8'h00, 0, 0);
        chk_log("binmid0", 3, 8'h00, 0, 1);
        chk_log("binmid1", 4, 8'h00, 0, 0);
        chk_log("binmid2", 5, 8'hFF, 0, 0);
        chk_log("binnew0", 8, 8'h00, 1, 0);
        chk_log("binnew1", 9, 8'hFF, 0, 0);
        finish_frame();
        idle(2);

        // Clamp mode at 0x40
        log_q.delete();
        threshold_i = 8'h40; binarize_i = 1'b0;
        beat(8'h3F); beat(8'h40); beat(8'hC3);
        idle(3);
        chk_log("clamp0", 0, 8'h00, 1, 0);
        chk_log("clamp1", 1, 8'h40, 0, 0);
        chk_log("clamp2", 2, 8'hC3, 0, 0);
        finish_frame();
        idle(2);

        // Overflow: 17 beats with sink stalled, then full + pop + push in one cycle
        log_q.delete();
        ready_i = 1'b0; threshold_i = 8'h00; binarize_i = 1'b0;
        for (int i = 1; i <= 17; i++) beat(8'(i));
        chk("ovf_fill", int'(fill_o), 16);
        chk("ovf_flag", int'(overflow_o), 1);
        chk("ovf_head", int'(pixel_o), 1);
        ready_i = 1'b1;
        beat(8'd99);
        chk("fullpop_fill", int'(fill_o), 15);
        chk("fullpop_flag", int'(overflow_o), 1);
        idle(17);
        chk("ovf_count", log_q.size(), 16);
        for (int i = 0; i < 16; i++)
            chk_log($sformatf("ovf%0d", i), i, i + 1, int'(i % FRAME == 0), int'(i % W == W - 1));
        finish_frame();
        idle(3);
        log_q.delete();
        beat(8'hAA);
        idle(2);
        chk_log("ovf_nextsof", 0, 8'hAA, 1, 0);
        chk("ovf_sticky", int'(overflow_o), 1);

        // Asynchronous reset mid-frame with 5 beats buffered
        ready_i = 1'b0;
        log_q.delete();
        for (int i = 0; i < 5; i++) beat(8'h20 + 8'(i));
        chk("prerst_fill", int'(fill_o), 5);
        #2 reset_i = 1'b1;
        #1;
        chk("arst_valid", int'(valid_o), 0);
        chk("arst_fill", int'(fill_o), 0);
        chk("arst_overflow", int'(overflow_o), 0);
        @(posedge clk_i); #2;
        reset_i = 1'b0;
        tb_idx = 0;
        @(posedge clk_i); #1;
        ready_i = 1'b1;
        beat(8'h33);
        idle(2);
        chk_log("arst_sof", 0, 8'h33, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
